ring_fsm: RTL and testbench

Parametrised, registered ring-sequencer FSM, the successor to the fixed 5-state combinational next-state block. Holds a state index in 0..NUM_STATES-1 and advances one step per accepted per-state advance request, either forward or backward around the ring. Adds a synchronous load, a minimum-dwell guard and a wrap indication. Used wherever a control path steps through a fixed cyclic sequence of phases.

---
 rtl/ring_fsm_pkg.sv | 17 +
 rtl/ring_fsm_next.sv | 41 ++++
 rtl/ring_fsm.sv | 94 +++++++++
 tb/tb_ring_fsm.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ring_fsm_pkg.sv
// Shared types and width helpers for the ring sequencer.
// Direction encoding and the state-index width rule live here so every file agrees.
package ring_fsm_pkg;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_BWD = 1'b1
    } dir_e;

    // Index width for a ring of n states; a ring of one still needs one bit.
    function automatic int unsigned state_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : ring_fsm_pkg

// File: rtl/ring_fsm_next.sv
// Combinational next-index and wrap computation for one step around the ring.
// Holds y when no step is granted; wrap flags the last<->first crossing.
module ring_fsm_next
    import ring_fsm_pkg::*;
#(
    parameter  int unsigned NUM_STATES = 5,
    localparam int unsigned STATE_W    = state_width(NUM_STATES)
) (
    input  logic [STATE_W-1:0] y,
    input  dir_e               dir,
    input  logic               advance_ok,
    output logic [STATE_W-1:0] next_y_c,
    output logic               wrap_c
);

    localparam logic [STATE_W-1:0] LAST  = STATE_W'(NUM_STATES - 1);
    localparam logic [STATE_W-1:0] FIRST = '0;

    always_comb begin
        next_y_c = y;
        wrap_c   = 1'b0;
        if (advance_ok) begin
            if (dir == DIR_FWD) begin
                if (y == LAST) begin
                    next_y_c = FIRST;
                    wrap_c   = 1'b1;
                end else begin
                    next_y_c = y + STATE_W'(1);
                end
            end else begin
                if (y == FIRST) begin
                    next_y_c = LAST;
                    wrap_c   = 1'b1;
                end else begin
                    next_y_c = y - STATE_W'(1);
                end
            end
        end
    end

endmodule : ring_fsm_next

// File: rtl/ring_fsm.sv
// Registered ring sequencer: steps one phase per granted request, with load,
// minimum-dwell guard, saturating dwell counter and a one-cycle wrap pulse.
module ring_fsm
    import ring_fsm_pkg::*;
#(
    parameter  int unsigned NUM_STATES = 5,
    parameter  int unsigned DWELL_W    = 4,
    parameter  int unsigned MIN_DWELL  = 0,
    localparam int unsigned STATE_W    = state_width(NUM_STATES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_STATES-1:0] adv,
    input  logic                  dir,
    input  logic                  load,
    input  logic [STATE_W-1:0]    load_state,
    output logic [STATE_W-1:0]    y,
    output logic [NUM_STATES-1:0] y_onehot,
    output logic                  wrap,
    output logic [DWELL_W-1:0]    dwell
);

    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

    logic                 dwell_ok;
    logic                 load_ok;
    logic                 advance_ok;
    logic [STATE_W-1:0]   step_y_c;
    logic                 step_wrap_c;
    logic [STATE_W-1:0]   y_nxt;
    logic                 wrap_nxt;
    logic [DWELL_W-1:0]   dwell_nxt;

    // Guard comparisons collapse to constants when they cannot fail.
    if (MIN_DWELL == 0) begin : g_no_dwell
        assign dwell_ok = 1'b1;
    end else begin : g_dwell
        assign dwell_ok = (dwell >= DWELL_W'(MIN_DWELL));
    end

    if (NUM_STATES == (1 << STATE_W)) begin : g_full_ring
        assign load_ok = 1'b1;
    end else begin : g_part_ring
        assign load_ok = (load_state < STATE_W'(NUM_STATES));
    end

    assign advance_ok = adv[y] & dwell_ok & ~load;

    ring_fsm_next #(
        .NUM_STATES (NUM_STATES)
    ) u_next (
        .y          (y),
        .dir        (dir_e'(dir)),
        .advance_ok (advance_ok),
        .next_y_c   (step_y_c),
        .wrap_c     (step_wrap_c)
    );

    // Next-state selection: load beats advance beats hold.
    always_comb begin
        y_nxt     = y;
        wrap_nxt  = 1'b0;
        dwell_nxt = (dwell == DWELL_MAX) ? dwell : dwell + DWELL_W'(1);
        if (load) begin
            y_nxt     = load_ok ? load_state : '0;
            dwell_nxt = '0;
        end else if (advance_ok) begin
            y_nxt     = step_y_c;
            wrap_nxt  = step_wrap_c;
            dwell_nxt = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            y     <= '0;
            wrap  <= 1'b0;
            dwell <= '0;
        end else begin
            y     <= y_nxt;
            wrap  <= wrap_nxt;
            dwell <= dwell_nxt;
        end
    end

    // One-hot view of the registered index, no added latency.
    always_comb begin
        y_onehot = '0;
        for (int unsigned i = 0; i < NUM_STATES; i++) begin
            y_onehot[i] = (y == STATE_W'(i));
        end
    end

endmodule : ring_fsm

// File: tb/tb_ring_fsm.sv
// Scoreboard bench for ring_fsm: four configurations share one stimulus stream
// and are compared each cycle against a behavioural ring model.
module tb_ring_fsm;

    logic       clock;
    logic       reset;
    logic [7:0] adv_w;
    logic       dir;
    logic       load;
    logic [2:0] load_state;

    logic [2:0] ya, yb, yd;
    logic [0:0] yc;
    logic [4:0] oha, ohb;
    logic [1:0] ohc;
    logic [7:0] ohd;
    logic       wa, wb, wc, wd;
    logic [3:0] da, db, dc, dd;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        int          id;
        int unsigned y;
        int unsigned dwell;
        int unsigned wrap;
    } mstate_t;

    mstate_t m [4];
    mstate_t sb [$];

    ring_fsm #(.NUM_STATES(5), .DWELL_W(4), .MIN_DWELL(0)) u_a (
        .clock(clock), .reset(reset), .adv(adv_w[4:0]), .dir(dir), .load(load),
        .load_state(load_state), .y(ya), .y_onehot(oha), .wrap(wa), .dwell(da));
    ring_fsm #(.NUM_STATES(5), .DWELL_W(4), .MIN_DWELL(3)) u_b (
        .clock(clock), .reset(reset), .adv(adv_w[4:0]), .dir(dir), .load(load),
        .load_state(load_state), .y(yb), .y_onehot(ohb), .wrap(wb), .dwell(db));
    ring_fsm #(.NUM_STATES(2), .DWELL_W(4), .MIN_DWELL(0)) u_c (
        .clock(clock), .reset(reset), .adv(adv_w[1:0]), .dir(dir), .load(load),
        .load_state(load_state[0:0]), .y(yc), .y_onehot(ohc), .wrap(wc), .dwell(dc));
    ring_fsm #(.NUM_STATES(8), .DWELL_W(4), .MIN_DWELL(0)) u_d (
        .clock(clock), .reset(reset), .adv(adv_w), .dir(dir), .load(load),
        .load_state(load_state), .y(yd), .y_onehot(ohd), .wrap(wd), .dwell(dd));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned ns_of(input int i);
        case (i)
            0, 1:    return 5;
            2:       return 2;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned md_of(input int i);
        return (i == 1) ? 3 : 0;
    endfunction

    function automatic int unsigned got_y(input int i);
        case (i)
            0:       return int'(ya);
            1:       return int'(yb);
            2:       return int'(yc);
            default: return int'(yd);
        endcase
    endfunction

    function automatic int unsigned got_oh(input int i);
        case (i)
            0:       return int'(oha);
            1:       return int'(ohb);
            2:       return int'(ohc);
            default: return int'(ohd);
        endcase
    endfunction

    function automatic int unsigned got_w(input int i);
        case (i)
            0:       return int'(wa);
            1:       return int'(wb);
            2:       return int'(wc);
            default: return int'(wd);
        endcase
    endfunction

    function automatic int unsigned got_d(input int i);
        case (i)
            0:       return int'(da);
            1:       return int'(db);
            2:       return int'(dc);
            default: return int'(dd);
        endcase
    endfunction

    // Reference behaviour of one ring for the inputs currently driven.
    function automatic mstate_t model_step(input mstate_t s, input int i);
        mstate_t     r;
        int unsigned n, ls;
        r  = s;
        n  = ns_of(i);
        ls = (n == 2) ? int'(load_state[0]) : int'(load_state);
        if (reset) begin
            r.y = 0; r.dwell = 0; r.wrap = 0;
        end else if (load) begin
            r.y = (ls < n) ? ls : 0; r.dwell = 0; r.wrap = 0;
        end else if (adv_w[s.y] && s.dwell >= md_of(i)) begin
            r.dwell = 0;
            if (!dir) begin
                r.wrap = (s.y == n - 1) ? 1 : 0;
                r.y    = (s.y == n - 1) ? 0 : s.y + 1;
            end else begin
                r.wrap = (s.y == 0) ? 1 : 0;
                r.y    = (s.y == 0) ? n - 1 : s.y - 1;
            end
        end else begin
            r.wrap  = 0;
            r.dwell = (s.dwell >= 15) ? 15 : s.dwell + 1;
        end
        return r;
    endfunction

    // Push expectations for this edge, clock it, then pop and compare.
    task automatic step();
        mstate_t e;
        for (int i = 0; i < 4; i++) begin
            m[i] = model_step(m[i], i);
            m[i].id = i;
            sb.push_back(m[i]);
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 0, 1);
            end else begin
                e = sb.pop_front();
                check($sformatf("y%0d", e.id), got_y(e.id), e.y);
                check($sformatf("onehot%0d", e.id), got_oh(e.id), 32'd1 << e.y);
                check($sformatf("wrap%0d", e.id), got_w(e.id), e.wrap);
                check($sformatf("dwell%0d", e.id), got_d(e.id), e.dwell);
                check($sformatf("range%0d", e.id), (got_y(e.id) < ns_of(e.id)) ? 1 : 0, 1);
            end
        end
    endtask

    initial begin
        int unsigned fwd_exp [6];
        fwd_exp = '{1, 2, 3, 4, 0, 1};
        for (int i = 0; i < 4; i++) m[i] = '{id: i, y: 0, dwell: 0, wrap: 0};

        reset = 1'b1; adv_w = '0; dir = 1'b0; load = 1'b0; load_state = '0;
        step();
        step();
        check("rst_y", int'(ya), 0);
        check("rst_dwell", int'(da), 0);
        check("rst_onehot", int'(oha), 1);

        // Forward every cycle around the 5-ring.
        reset = 1'b0; adv_w = 8'hFF; dir = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("fwd_y", int'(ya), fwd_exp[i]);
            check("fwd_wrap", int'(wa), (fwd_exp[i] == 0) ? 1 : 0);
        end

        // Backward wrap from 0, then hold and saturate dwell.
        load = 1'b1; load_state = 3'd0;
        step();
        load = 1'b0; dir = 1'b1; adv_w = 8'h01;
        step();
        check("bwd_y", int'(ya), 4);
        check("bwd_wrap", int'(wa), 1);
        for (int i = 0; i < 16; i++) begin
            step();
            check("hold_y", int'(ya), 4);
            check("hold_dwell", int'(da), (i + 1 > 15) ? 15 : i + 1);
        end

        // Minimum dwell of 3 on instance b.
        reset = 1'b1;
        step();
        reset = 1'b0; adv_w = 8'hFF; dir = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("md_y", int'(yb), k / 4);
            check("md_dwell", int'(db), k % 4);
        end

        // Out-of-range load, then load winning over advance.
        load = 1'b1; load_state = 3'd6; adv_w = 8'h00;
        step();
        check("load_oob_y", int'(ya), 0);
        check("load_oob_dwell", int'(da), 0);
        check("load_n8_y", int'(yd), 6);
        load_state = 3'd3; adv_w = 8'hFF;
        step();
        check("load_win_y", int'(ya), 3);
        check("load_win_wrap", int'(wa), 0);

        // Reset mid-sequence discards load and advance.
        load_state = 3'd2;
        step();
        check("pre_rst_y", int'(ya), 2);
        reset = 1'b1; load = 1'b1; adv_w = 8'hFF; load_state = 3'd4;
        step();
        check("mid_rst_y", int'(ya), 0);
        check("mid_rst_dwell", int'(da), 0);
        check("mid_rst_wrap", int'(wa), 0);
        reset = 1'b0; load = 1'b0;

        // Random sweep across all configurations.
        for (int i = 0; i < 400; i++) begin
            adv_w      = 8'($urandom);
            dir        = 1'($urandom);
            load       = ($urandom_range(0, 19) == 0);
            reset      = ($urandom_range(0, 49) == 0);
            load_state = 3'($urandom);
            step();
        end

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ring_fsm
